multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core. It replaces single-cycle decode with a sequenced controller driving a shared-memory datapath: one memory port, one ALU, and IR/OldPC/Data/ALUOut holding registers. Adds an optional memory-ready handshake, full B-type branch conditions, JALR, LUI, AUIPC and illegal-opcode reporting.

---
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/multicycle_controller.sv | 272 +++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The datapath supplies the instruction fields, the ALU flags and the memory
// ready strobe. The controller returns every datapath enable and mux select.
//   master : controller side (drives the controls, reads IR fields and flags)
//   slave  : datapath side  (drives IR fields and flags, reads the controls)
// ALUCTRL_W sets the ALUControl width. It must match the controller's parameter.
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 4
);
  // datapath -> controller
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 Zero;
  logic                 Lt;
  logic                 Ltu;
  logic                 mem_ready;
  // controller -> datapath
  logic                 mem_req;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic                 RegWrite;
  logic [2:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 illegal_instr;

  modport master (
    input  op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl, illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing controller for a multicycle RV32I core. The datapath shares one
// memory port and one ALU between fetch and data access.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; returns the FSM to FETCH
//   ctl    multicycle_controller_if.master, which carries IR fields, ALU
//          flags, mem_ready and all datapath controls
// The state register is the only storage. Controls are a Moore decode of the
// state. ImmSrc and the EXEC ALU operation also decode combinationally from
// the IR fields.
// MEM_HANDSHAKE=0 ignores mem_ready, so every access takes one cycle.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ALUCTRL_W     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    JAL     = 4'd10,
    JALR    = 4'd11,
    LUI     = 4'd12,
    AUIPC   = 4'd13,
    ILLEGAL = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // ALU operation for R/I-type. SUB exists only for register forms.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       op5,
                                            input logic       f7b5);
    case (f3)
      3'b000:  alu_decode = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      3'b111:  alu_decode = ALU_AND;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  // Branch condition from the ALU flags. Reserved funct3 values never take.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       z,
                                        input logic       lt,
                                        input logic       ltu);
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = ~z;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = ~ltu;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  // Immediate format selected by opcode.
  function automatic logic [2:0] imm_select(input logic [6:0] opc);
    case (opc)
      OP_STORE:          imm_select = 3'b001;
      OP_BRANCH:         imm_select = 3'b010;
      OP_JAL:            imm_select = 3'b011;
      OP_LUI, OP_AUIPC:  imm_select = 3'b100;
      default:           imm_select = 3'b000;
    endcase
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic       ready_s;
  logic       mem_req_s;
  logic       pc_write_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic       reg_write_s;
  logic       illegal_s;
  logic [3:0] alu_op_s;

  assign ready_s = MEM_HANDSHAKE ? ctl.mem_ready : 1'b1;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:   next_state_s = ready_s ? DECODE : FETCH;
      DECODE: begin
        case (ctl.op)
          OP_LOAD, OP_STORE: next_state_s = MEMADR;
          OP_REG:            next_state_s = EXECR;
          OP_IMM:            next_state_s = EXECI;
          OP_BRANCH:         next_state_s = BRANCH;
          OP_JAL:            next_state_s = JAL;
          OP_JALR:           next_state_s = JALR;
          OP_LUI:            next_state_s = LUI;
          OP_AUIPC:          next_state_s = AUIPC;
          default:           next_state_s = ILLEGAL;
        endcase
      end
      // op[5] separates a store (0100011) from a load (0000011).
      MEMADR:  next_state_s = ctl.op[5] ? MEMWR : MEMREAD;
      MEMREAD: next_state_s = ready_s ? MEMWB : MEMREAD;
      MEMWB:   next_state_s = FETCH;
      MEMWR:   next_state_s = ready_s ? FETCH : MEMWR;
      EXECR:   next_state_s = ALUWB;
      EXECI:   next_state_s = ALUWB;
      ALUWB:   next_state_s = FETCH;
      BRANCH:  next_state_s = FETCH;
      JAL:     next_state_s = ALUWB;
      JALR:    next_state_s = JAL;
      LUI:     next_state_s = ALUWB;
      AUIPC:   next_state_s = ALUWB;
      ILLEGAL: next_state_s = FETCH;
      default: next_state_s = FETCH;
    endcase
  end

  // Moore control decode of the current state.
  always_comb begin
    mem_req_s    = 1'b0;
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    alu_op_s     = ALU_ADD;
    case (state_r)
      FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = ready_s;
        pc_write_s   = ready_s;
      end
      DECODE: begin
        // Precompute the PC-relative target into ALUOut.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      MEMWR: begin
        mem_req_s   = 1'b1;
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = alu_decode(ctl.funct3, ctl.op[5], ctl.funct7b5);
      end
      EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = alu_decode(ctl.funct3, ctl.op[5], ctl.funct7b5);
      end
      ALUWB: begin
        reg_write_s = 1'b1;
      end
      BRANCH: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = ALU_SUB;
        pc_write_s  = branch_taken(ctl.funct3, ctl.Zero, ctl.Lt, ctl.Ltu);
        illegal_s   = (ctl.funct3[2:1] == 2'b01);
      end
      JAL: begin
        // PC <- ALUOut. The ALU forms OldPC+4 for the link write in ALUWB.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
      end
      JALR: begin
        // The target goes straight to PC. JAL then sets PC again from the
        // ALUOut copy of the same target while it forms the link value.
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b01;
        result_src_s = 2'b10;
        pc_write_s   = 1'b1;
      end
      LUI: begin
        alu_src_a_s = 2'b11;
        alu_src_b_s = 2'b01;
      end
      AUIPC: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      ILLEGAL: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  // Enables are forced low while reset is held so nothing commits.
  assign ctl.mem_req       = mem_req_s;
  assign ctl.PCWrite       = pc_write_s  & ~reset;
  assign ctl.AdrSrc        = adr_src_s;
  assign ctl.MemWrite      = mem_write_s & ~reset;
  assign ctl.IRWrite       = ir_write_s  & ~reset;
  assign ctl.ResultSrc     = result_src_s;
  assign ctl.ALUSrcA       = alu_src_a_s;
  assign ctl.ALUSrcB       = alu_src_b_s;
  assign ctl.RegWrite      = reg_write_s & ~reset;
  assign ctl.illegal_instr = illegal_s   & ~reset;
  assign ctl.ImmSrc        = imm_select(ctl.op);
  assign ctl.ALUControl    = ALUCTRL_W'(alu_op_s);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. It drives one handshaking instance and one
// instance with MEM_HANDSHAKE=0. Each instruction is checked as a whole:
// cycle count, number of write strobes, ALU op and immediate select.
module tb_multicycle_controller;

  localparam logic [6:0] OPL  = 7'b0000011;
  localparam logic [6:0] OPS  = 7'b0100011;
  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPB  = 7'b1100011;
  localparam logic [6:0] OPJ  = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111;
  localparam logic [6:0] OPLU = 7'b0110111;
  localparam logic [6:0] OPAU = 7'b0010111;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       lt;
    logic       ltu;
    int         fw;    // fetch wait cycles
    int         mw;    // data wait cycles
    int         cpi;   // total cycles FETCH..last state
    int         rw;    // RegWrite cycles
    int         mwc;   // MemWrite cycles
    int         pcw;   // PCWrite cycles after fetch
    int         ill;   // illegal_instr cycles
    int         adr;   // AdrSrc=1 cycles
    logic [3:0] alu;   // ALU op in the last RD1-sourced cycle, F if none
    logic [1:0] rs;    // ResultSrc on the RegWrite cycle, 11 if none
    logic [2:0] imm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [6:0] op_v;
  logic [2:0] f3_v;
  logic       f7_v, z_v, lt_v, ltu_v, rdy_v;
  logic       sel;   // 0: handshake instance, 1: no-handshake instance

  multicycle_controller_if #(.ALUCTRL_W(6)) ifa ();
  multicycle_controller_if #(.ALUCTRL_W(4)) ifb ();

  assign ifa.op = op_v;   assign ifb.op = op_v;
  assign ifa.funct3 = f3_v;   assign ifb.funct3 = f3_v;
  assign ifa.funct7b5 = f7_v; assign ifb.funct7b5 = f7_v;
  assign ifa.Zero = z_v;  assign ifb.Zero = z_v;
  assign ifa.Lt = lt_v;   assign ifb.Lt = lt_v;
  assign ifa.Ltu = ltu_v; assign ifb.Ltu = ltu_v;
  assign ifa.mem_ready = rdy_v;
  assign ifb.mem_ready = 1'b0;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .ALUCTRL_W(6)) dut (
    .clk(clk), .reset(reset), .ctl(ifa.master));
  multicycle_controller #(.MEM_HANDSHAKE(1'b0), .ALUCTRL_W(4)) dut_nohs (
    .clk(clk), .reset(reset), .ctl(ifb.master));

  logic       o_req, o_pcw, o_adr, o_mw, o_irw, o_rw, o_ill;
  logic [1:0] o_rs, o_sa;
  logic [2:0] o_imm;
  logic [3:0] o_alu;
  assign o_req = sel ? ifb.mem_req       : ifa.mem_req;
  assign o_pcw = sel ? ifb.PCWrite       : ifa.PCWrite;
  assign o_adr = sel ? ifb.AdrSrc        : ifa.AdrSrc;
  assign o_mw  = sel ? ifb.MemWrite      : ifa.MemWrite;
  assign o_irw = sel ? ifb.IRWrite       : ifa.IRWrite;
  assign o_rw  = sel ? ifb.RegWrite      : ifa.RegWrite;
  assign o_ill = sel ? ifb.illegal_instr : ifa.illegal_instr;
  assign o_rs  = sel ? ifb.ResultSrc     : ifa.ResultSrc;
  assign o_sa  = sel ? ifb.ALUSrcA       : ifa.ALUSrcA;
  assign o_imm = sel ? ifb.ImmSrc        : ifa.ImmSrc;
  assign o_alu = sel ? ifb.ALUControl    : ifa.ALUControl[3:0];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic z, input logic lt, input logic ltu,
                              input int fw, input int mw, input int cpi, input int rw,
                              input int mwc, input int pcw, input int ill, input int adr,
                              input logic [3:0] alu, input logic [1:0] rs, input logic [2:0] imm);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.ltu = ltu;
    v.fw = fw; v.mw = mw; v.cpi = cpi; v.rw = rw; v.mwc = mwc; v.pcw = pcw;
    v.ill = ill; v.adr = adr; v.alu = alu; v.rs = rs; v.imm = imm;
    return v;
  endfunction

  // Instruction-level reference: class of instruction -> cost and effects.
  function automatic vec_t model(input vec_t in, input bit hs);
    vec_t       v;
    logic [3:0] base [8];
    logic       cond;
    int         w;
    base[0] = 4'h0; base[1] = 4'h7; base[2] = 4'h5; base[3] = 4'h6;
    base[4] = 4'h4; base[5] = 4'h8; base[6] = 4'h3; base[7] = 4'h2;
    v = in;
    w = hs ? in.mw : 0;
    v.rw = 0; v.mwc = 0; v.pcw = 0; v.ill = 0; v.adr = 0;
    v.alu = 4'hF; v.rs = 2'b11; v.imm = 3'b000;
    case (in.op)
      OPL:  begin v.cpi = 5 + w; v.rw = 1; v.rs = 2'b01; v.adr = 1 + w; v.alu = 4'h0; end
      OPS:  begin v.cpi = 4 + w; v.mwc = 1 + w; v.adr = 1 + w; v.alu = 4'h0; v.imm = 3'b001; end
      OPR, OPI: begin
        v.cpi = 4; v.rw = 1; v.rs = 2'b00;
        v.alu = base[in.f3];
        if (in.f3 == 3'd0 && in.op == OPR && in.f7) v.alu = 4'h1;
        if (in.f3 == 3'd5 && in.f7) v.alu = 4'h9;
      end
      OPB: begin
        v.cpi = 3; v.alu = 4'h1; v.imm = 3'b010;
        cond  = in.f3[2] ? (in.f3[1] ? in.ltu : in.lt) : in.z;
        if (in.f3 == 3'd2 || in.f3 == 3'd3) v.ill = 1;
        else v.pcw = (cond ^ in.f3[0]) ? 1 : 0;
      end
      OPJ:  begin v.cpi = 4; v.rw = 1; v.rs = 2'b00; v.pcw = 1; v.imm = 3'b011; end
      OPJR: begin v.cpi = 5; v.rw = 1; v.rs = 2'b00; v.pcw = 2; v.alu = 4'h0; end
      OPLU, OPAU: begin v.cpi = 4; v.rw = 1; v.rs = 2'b00; v.imm = 3'b100; end
      default: begin v.cpi = 3; v.ill = 1; end
    endcase
    v.cpi += hs ? in.fw : 0;
    return v;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; returns at the
  // negedge where the next FETCH is seen.
  task automatic run_instr(input vec_t v, input string tag);
    int cyc, wc, rw, mwc, pw, il, adr;
    logic [3:0] alu;
    logic [1:0] rs;
    bit eff, done, imm_bad, irw_bad, hi_bad;
    op_v = v.op; f3_v = v.f3; f7_v = v.f7; z_v = v.z; lt_v = v.lt; ltu_v = v.ltu;
    cyc = 0; wc = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      if (wc < v.fw) begin rdy_v = 1'b0; wc++; end
      else rdy_v = 1'b1;
      eff = sel ? 1'b1 : rdy_v;
      #1;
      cyc++;
      chk({tag, " fetch"}, int'({o_req, o_adr, o_irw, o_pcw, o_rw, o_mw, o_ill}),
          int'({1'b1, 1'b0, eff, eff, 1'b0, 1'b0, 1'b0}));
      if (eff) done = 1'b1;
      @(negedge clk);
    end
    chk({tag, " fetch_bound"}, int'(done), 1);
    wc = 0; rw = 0; mwc = 0; pw = 0; il = 0; adr = 0;
    alu = 4'hF; rs = 2'b11; imm_bad = 0; irw_bad = 0; hi_bad = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      if (o_req && !o_adr) begin
        done = 1'b1;
      end else begin
        if (o_req && o_adr) begin
          if (wc < v.mw) begin rdy_v = 1'b0; wc++; end
          else rdy_v = 1'b1;
        end else begin
          rdy_v = 1'($urandom_range(0, 1));
        end
        #1;
        cyc++;
        if (o_rw)  begin rw++; rs = o_rs; end
        if (o_mw)  mwc++;
        if (o_pcw) pw++;
        if (o_ill) il++;
        if (o_adr) adr++;
        if (o_sa == 2'b10) alu = o_alu;
        if (o_imm != v.imm) imm_bad = 1'b1;
        if (o_irw) irw_bad = 1'b1;
        if (!sel && ifa.ALUControl[5:4] != 2'b00) hi_bad = 1'b1;
        @(negedge clk);
      end
    end
    chk({tag, " body_bound"}, int'(done), 1);
    chk({tag, " cycles"}, cyc, v.cpi);
    chk({tag, " regwrite"}, rw, v.rw);
    chk({tag, " memwrite"}, mwc, v.mwc);
    chk({tag, " pcwrite"}, pw, v.pcw);
    chk({tag, " illegal"}, il, v.ill);
    chk({tag, " adrsrc"}, adr, v.adr);
    chk({tag, " aluctl"}, int'(alu), int'(v.alu));
    chk({tag, " resultsrc"}, int'(rs), int'(v.rs));
    chk({tag, " immsrc_err"}, int'(imm_bad), 0);
    chk({tag, " irwrite_err"}, int'({irw_bad, hi_bad}), 0);
  endtask

  // Reset pulse; leaves the bench at a negedge with both FSMs in FETCH.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic [6:0] ops [9];

  initial begin
    reset = 1'b1; sel = 1'b0; rdy_v = 1'b1;
    op_v = OPR; f3_v = 3'd0; f7_v = 1'b0; z_v = 1'b0; lt_v = 1'b0; ltu_v = 1'b0;
    ops[0] = OPL; ops[1] = OPS; ops[2] = OPR; ops[3] = OPI; ops[4] = OPB;
    ops[5] = OPJ; ops[6] = OPJR; ops[7] = OPLU; ops[8] = OPAU;

    // Reset state: FETCH requests memory, every enable held low.
    @(negedge clk); #1;
    chk("reset_a", int'({ifa.mem_req, ifa.AdrSrc, ifa.IRWrite, ifa.PCWrite, ifa.RegWrite,
                         ifa.MemWrite, ifa.illegal_instr}), int'(7'b1000000));
    chk("reset_b", int'({ifb.mem_req, ifb.IRWrite, ifb.PCWrite, ifb.RegWrite}), int'(4'b1000));
    @(negedge clk);
    reset = 1'b0;

    // op, f3, f7, z, lt, ltu, fw, mw | cpi, rw, mwc, pcw, ill, adr, alu, rs, imm
    tbl.push_back(mk(OPR, 3'd0, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h0, 2'b00, 3'b000));
    tbl.push_back(mk(OPR, 3'd0, 1'b1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h1, 2'b00, 3'b000));
    tbl.push_back(mk(OPI, 3'd0, 1'b1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h0, 2'b00, 3'b000));
    tbl.push_back(mk(OPI, 3'd5, 1'b1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h9, 2'b00, 3'b000));
    tbl.push_back(mk(OPR, 3'd5, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h8, 2'b00, 3'b000));
    tbl.push_back(mk(OPR, 3'd3, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h6, 2'b00, 3'b000));
    tbl.push_back(mk(OPI, 3'd2, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h5, 2'b00, 3'b000));
    tbl.push_back(mk(OPR, 3'd7, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h2, 2'b00, 3'b000));
    tbl.push_back(mk(OPI, 3'd6, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h3, 2'b00, 3'b000));
    tbl.push_back(mk(OPR, 3'd4, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h4, 2'b00, 3'b000));
    tbl.push_back(mk(OPI, 3'd1, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h7, 2'b00, 3'b000));
    tbl.push_back(mk(OPL, 3'd2, 1'b0, 0, 0, 0, 0, 3, 8, 1, 0, 0, 0, 4, 4'h0, 2'b01, 3'b000));
    tbl.push_back(mk(OPS, 3'd2, 1'b0, 0, 0, 0, 0, 2, 6, 0, 3, 0, 0, 3, 4'h0, 2'b11, 3'b001));
    tbl.push_back(mk(OPB, 3'd5, 1'b0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 4'h1, 2'b11, 3'b010));
    tbl.push_back(mk(OPB, 3'd5, 1'b0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 4'h1, 2'b11, 3'b010));
    tbl.push_back(mk(OPB, 3'd0, 1'b0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 4'h1, 2'b11, 3'b010));
    tbl.push_back(mk(OPB, 3'd1, 1'b0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 4'h1, 2'b11, 3'b010));
    tbl.push_back(mk(OPB, 3'd6, 1'b0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0, 0, 4'h1, 2'b11, 3'b010));
    tbl.push_back(mk(OPB, 3'd2, 1'b0, 0, 1, 1, 0, 0, 3, 0, 0, 0, 1, 0, 4'h1, 2'b11, 3'b010));
    tbl.push_back(mk(OPJR, 3'd0, 1'b0, 0, 0, 0, 0, 0, 5, 1, 0, 2, 0, 0, 4'h0, 2'b00, 3'b000));
    tbl.push_back(mk(OPJ, 3'd0, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 4'hF, 2'b00, 3'b011));
    tbl.push_back(mk(OPLU, 3'd0, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'hF, 2'b00, 3'b100));
    tbl.push_back(mk(OPAU, 3'd0, 1'b0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'hF, 2'b00, 3'b100));
    tbl.push_back(mk(7'h7F, 3'd0, 1'b0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 4'hF, 2'b11, 3'b000));
    tbl.push_back(mk(OPR, 3'd0, 1'b0, 0, 0, 0, 2, 0, 6, 1, 0, 0, 0, 0, 4'h0, 2'b00, 3'b000));

    for (int i = 0; i < tbl.size(); i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a load waiting in MEMREAD.
    op_v = OPL; f3_v = 3'd2; rdy_v = 1'b1;
    @(negedge clk); rdy_v = 1'b0;   // DECODE
    @(negedge clk);                 // MEMADR
    @(negedge clk); #1;             // MEMREAD
    chk("memread_wait", int'({ifa.mem_req, ifa.AdrSrc, ifa.RegWrite}), int'(3'b110));
    reset = 1'b1; rdy_v = 1'b1; #1;
    chk("rst_mid", int'({ifa.mem_req, ifa.AdrSrc, ifa.RegWrite, ifa.IRWrite, ifa.PCWrite}),
        int'(5'b10000));
    @(negedge clk); reset = 1'b0; rdy_v = 1'b0; #1;
    chk("rst_rel", int'({ifa.mem_req, ifa.AdrSrc, ifa.RegWrite, ifa.IRWrite, ifa.PCWrite}),
        int'(5'b10000));
    @(negedge clk); rdy_v = 1'b1; #1;
    chk("rst_first_rdy", int'({ifa.IRWrite, ifa.PCWrite, ifa.RegWrite}), int'(3'b110));
    @(negedge clk); #1;
    chk("rst_then_decode", int'({ifa.mem_req, ifa.IRWrite, ifa.PCWrite}), int'(3'b000));
    do_reset();

    // Randomized instructions against the reference model.
    for (int i = 0; i < 150; i++) begin
      rv.op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      rv.f3  = 3'($urandom); rv.f7 = 1'($urandom);
      rv.z   = 1'($urandom); rv.lt = 1'($urandom); rv.ltu = 1'($urandom);
      rv.fw  = $urandom_range(0, 2); rv.mw = $urandom_range(0, 3);
      run_instr(model(rv, 1'b1), $sformatf("rnd%0d", i));
    end

    // No-handshake instance: mem_ready is tied low and must not stall.
    do_reset();
    sel = 1'b1;
    rv = mk(OPL, 3'd2, 1'b0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, 3'b000);
    run_instr(model(rv, 1'b0), "nohs_lw");
    chk("nohs_lw_cpi_const", model(rv, 1'b0).cpi, 5);
    for (int i = 0; i < 40; i++) begin
      rv.op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      rv.f3  = 3'($urandom); rv.f7 = 1'($urandom);
      rv.z   = 1'($urandom); rv.lt = 1'($urandom); rv.ltu = 1'($urandom);
      rv.fw  = $urandom_range(0, 2); rv.mw = $urandom_range(0, 3);
      run_instr(model(rv, 1'b0), $sformatf("nohs%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
